// File: rtl/mips_fetch_pkg.sv
// Shared constants and types for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

  localparam int XLEN      = 32;
  localparam int J_INDEX_W = 26;

  localparam logic [XLEN-1:0] NOP_WORD             = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  // Instruction fetches are word aligned, so redirect targets drop bits [1:0].
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: reset > flush (bubble) > stall (hold) > load.
module ifid_register
  import mips_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic            valid_out
);

  ifid_t ifid_q;
  ifid_t ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    if (flush) begin
      // The bubble still carries PC+4 so downstream debug sees where it came from.
      ifid_d.instr    = NOP;
      ifid_d.pc_plus4 = pc_plus4_in;
      ifid_d.valid    = 1'b0;
    end else if (!stall) begin
      ifid_d.instr    = instr_in;
      ifid_d.pc_plus4 = pc_plus4_in;
      ifid_d.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q.instr    <= NOP;
      ifid_q.pc_plus4 <= '0;
      ifid_q.valid    <= 1'b0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign instr_out    = ifid_q.instr;
  assign pc_plus4_out = ifid_q.pc_plus4;
  assign valid_out    = ifid_q.valid;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC register with branch/jump redirect and the IF/ID register.
module instruction_fetch
  import mips_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [XLEN-1:0] NOP_WORD     = mips_fetch_pkg::NOP_WORD
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 STALL,
  input  logic                 FLUSH,
  input  logic                 BRANCH_TAKEN,
  input  logic [XLEN-1:0]      BRANCH_TARGET,
  input  logic                 JUMP,
  input  logic [J_INDEX_W-1:0] JUMP_INDEX,
  output logic [XLEN-1:0]      ADDRESS,
  input  logic [XLEN-1:0]      INSTRUCTION,
  output logic [XLEN-1:0]      IFID_INSTRUCTION,
  output logic [XLEN-1:0]      IFID_PC_PLUS4,
  output logic                 IFID_VALID
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jump_target;
  logic            redirect;

  assign pc_plus4    = pc_q + 32'd4;  // wraps modulo 2^32 by width
  assign jump_target = {IFID_PC_PLUS4[31:28], JUMP_INDEX, 2'b00};
  assign redirect    = BRANCH_TAKEN | JUMP;

  // Redirects beat STALL: the hazard unit never holds a control transfer.
  always_comb begin
    pc_d = pc_plus4;
    if (BRANCH_TAKEN) begin
      pc_d = word_align(BRANCH_TARGET);
    end else if (JUMP) begin
      pc_d = word_align(jump_target);
    end else if (STALL) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign ADDRESS = pc_q;

  ifid_register #(
    .NOP (NOP_WORD)
  ) u_ifid (
    .clk          (CLK),
    .rst          (RST),
    .stall        (STALL),
    .flush        (FLUSH | redirect),
    .instr_in     (INSTRUCTION),
    .pc_plus4_in  (pc_plus4),
    .instr_out    (IFID_INSTRUCTION),
    .pc_plus4_out (IFID_PC_PLUS4),
    .valid_out    (IFID_VALID)
  );

endmodule
